prbs7_ber_ctrl: RTL
===================

# prbs7_ber_ctrl

Sequencer and checker for PRBS7 link tests in the ETROC2 readout path. It configures and gates the PRBS7 word generator through that generator's reset, disable and seed controls. It self-synchronises a local PRBS7 predictor to the returned word stream, then counts checked words and bit errors for a programmed test length. Lock loss and recovery are reported to slow control.

## Interface
- WORDWIDTH, 16, bits per PRBS word; must be >= 7 and match the generator.
- SYNC_WORDS, 4, consecutive error-free words required to declare lock.
- LOSS_WORDS, 4, consecutive errored words that drop lock.
- CNTW, 32, width of word and error counters.

Ports:
- clk  in  1  40 MHz word clock; sole clock.
- reset  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; begins a test from IDLE or DONE, ignored otherwise.
- abort  in  1  level; forces IDLE from any state, has priority over start.
- seed  in  7  generator seed; 7'h00 is replaced by 7'h7F.
- num_words  in  CNTW  words to check; 0 means run until abort.
- rx_valid  in  1  rx_data holds a valid word this cycle.
- rx_data  in  WORDWIDTH  returned word, bit 0 first in time.
- gen_reset  out  1  active-low load strobe to the generator.
- gen_dis  out  1  generator hold.
- gen_seed  out  7  seed presented to the generator.
- busy  out  1  state is SEED, SYNC or CHECK.
- locked  out  1  state is CHECK.
- done  out  1  state is DONE.
- lock_lost  out  1  sticky; set on any CHECK->SYNC drop, cleared by start.
- word_count  out  CNTW  words checked in CHECK.
- err_count  out  CNTW  bit errors counted, saturating at all-ones.

## Operation
- States: IDLE, SEED, SYNC, CHECK, DONE. All outputs are registered.
- IDLE: gen_dis=1, gen_reset=1. On start: latch gen_seed, clear word_count, err_count and lock_lost, then go to SEED.
- SEED: one cycle only. gen_reset=0, gen_dis=0. Go to SYNC.
- SYNC: gen_dis=0.
  - On each rx_valid word, compare rx_data with the predictor's next word.
  - On a match, increment the match count and advance the predictor from its own state.
  - On a mismatch, or on the first word after entry, load the predictor state from {rx_data[W-1], rx_data[W-2], ..., rx_data[W-7]} (MSB first) and zero the match count.
  - When the match count reaches SYNC_WORDS, go to CHECK.
- Predictor recurrence per bit: out = s[1]^s[0]; s <= {out, s[6:1]}; bit i of the word is the i-th output.
- CHECK:
  - On each rx_valid word, word_count += 1 and err_count += popcount(rx_data ^ expected), saturating.
  - The predictor always advances from the expected state, never from rx_data, so errors do not multiply.
  - A nonzero popcount increments the bad-word run; a clean word zeroes it.
  - When the bad-word run reaches LOSS_WORDS: set lock_lost, go to SYNC, and keep word_count and err_count.
  - When num_words != 0 and the word_count update reaches num_words, go to DONE. This takes priority over a simultaneous lock loss.
- DONE: gen_dis=1. Counters are frozen. start re-runs the test; abort returns to IDLE.
- abort: next state IDLE, gen_dis=1, counters hold their values.
- Idle cycles (rx_valid=0) change nothing except the SEED->SYNC transition.

## Timing
- Reset values:
  - state IDLE; gen_reset=1, gen_dis=1, gen_seed=7'h7F.
  - busy=0, locked=0, done=0, lock_lost=0.
  - word_count=0, err_count=0; predictor 7'h7F; run counters 0.
- start sampled high at edge N gives gen_reset=0 during cycle N+1, SYNC from N+2, busy=1 from N+1.
- Counter updates are visible the cycle after the rx_valid word.
- locked rises the cycle after the SYNC_WORDS-th matching word. done rises the cycle after the num_words-th checked word.
- Reset assertion mid-test returns to the reset values immediately (asynchronous); release is synchronous to the next clk edge.

## Test plan
- Loopback generator to rx with a 2-cycle delay, seed=7'h7F, num_words=100: locked after 5 valid words, done, word_count=100, err_count=0, lock_lost=0.
- Same setup with bit 3 of checked word 50 flipped: err_count=1, locked stays 1, word_count=100.
- Corrupt 4 consecutive words in CHECK: lock_lost=1, locked=0, state SYNC, relock after 5 clean words; err_count includes every flipped bit; done still reached.
- seed=7'h00: gen_seed=7'h7F during SEED; all-zero rx_data never locks (busy=1, locked=0 indefinitely).
- num_words=0 with rx_valid toggling 50%: never done; word_count equals the number of valid words seen in CHECK; abort sets busy=0 the next cycle with counters held.
- Assert reset during CHECK with word_count=37: all outputs return to reset values asynchronously; a later start with the same seed gives a clean run.

Source files
------------

// File: rtl/prbs7_ber_ctrl_if.sv
// prbs7_ber_ctrl_if
//
// Groups the link-side signals of the PRBS7 BER controller: the control
// lines that drive the PRBS7 word generator and the returned word stream.
//
// Signals:
//   gen_reset  active-low load strobe; the generator loads gen_seed
//   gen_dis    generator hold
//   gen_seed   seed presented to the generator
//   rx_valid   rx_data holds a valid word this cycle
//   rx_data    returned word, bit 0 first in time
//
// Modports:
//   master  the controller (drives generator controls, receives words)
//   slave   the generator/link side
interface prbs7_ber_ctrl_if #(
    parameter int WORDWIDTH = 16
);
    logic                 gen_reset;
    logic                 gen_dis;
    logic [6:0]           gen_seed;
    logic                 rx_valid;
    logic [WORDWIDTH-1:0] rx_data;

    modport master (
        output gen_reset,
        output gen_dis,
        output gen_seed,
        input  rx_valid,
        input  rx_data
    );

    modport slave (
        input  gen_reset,
        input  gen_dis,
        input  gen_seed,
        output rx_valid,
        output rx_data
    );
endinterface

// File: rtl/prbs7_ber_ctrl.sv
// prbs7_ber_ctrl
//
// Sequencer and checker for PRBS7 link tests. Seeds and gates the PRBS7
// word generator, self-synchronises a local predictor to the returned word
// stream, then counts checked words and bit errors for a programmed test
// length. Lock loss is reported through a sticky flag.
//
// Ports:
//   clk         word clock (sole clock)
//   reset       asynchronous, active-low reset
//   start       one-cycle pulse; begins a test from IDLE or DONE
//   abort       level; forces IDLE from any state, wins over start
//   seed        generator seed; 7'h00 is replaced by 7'h7F
//   num_words   number of words to check; 0 runs until abort
//   link        generator controls and returned word stream (master side)
//   busy        test in progress (SEED, SYNC or CHECK)
//   locked      predictor locked (CHECK)
//   done        test complete (DONE)
//   lock_lost   sticky; set on every CHECK->SYNC drop, cleared by start
//   word_count  words checked while locked
//   err_count   bit errors counted, saturating at all-ones
module prbs7_ber_ctrl #(
    parameter int WORDWIDTH  = 16,
    parameter int SYNC_WORDS = 4,
    parameter int LOSS_WORDS = 4,
    parameter int CNTW       = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  abort,
    input  logic [6:0]            seed,
    input  logic [CNTW-1:0]       num_words,
    prbs7_ber_ctrl_if.master      link,
    output logic                  busy,
    output logic                  locked,
    output logic                  done,
    output logic                  lock_lost,
    output logic [CNTW-1:0]       word_count,
    output logic [CNTW-1:0]       err_count
);

    localparam int W   = WORDWIDTH;
    localparam int PCW = $clog2(W + 1);
    localparam int MCW = $clog2(SYNC_WORDS + 1);
    localparam int BCW = $clog2(LOSS_WORDS + 1);

    localparam logic [MCW-1:0] SYNC_LAST = MCW'(SYNC_WORDS - 1);
    localparam logic [BCW-1:0] LOSS_LAST = BCW'(LOSS_WORDS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEED,
        S_SYNC,
        S_CHECK,
        S_DONE
    } state_t;

    state_t          state;
    logic [6:0]      pred_state;
    logic [MCW-1:0]  match_cnt;
    logic [BCW-1:0]  bad_run;
    logic            sync_first;

    logic            gen_reset_q;
    logic            gen_dis_q;
    logic [6:0]      gen_seed_q;

    logic [W-1:0]    exp_word;
    logic [6:0]      exp_next;
    logic [PCW-1:0]  bit_errs;
    logic [6:0]      rx_state;
    logic            word_match;
    logic [CNTW-1:0] word_inc;
    logic [CNTW:0]   err_wide;
    logic [CNTW-1:0] err_sum;

    // One predicted word: bit i is the i-th output of the recurrence
    // out = s[1]^s[0], s <= {out, s[6:1]}.
    function automatic logic [W-1:0] prbs_word(input logic [6:0] s);
        logic [6:0]   t;
        logic [W-1:0] w;
        t = s;
        w = '0;
        for (int i = 0; i < W; i++) begin
            w[i] = t[1] ^ t[0];
            t    = {w[i], t[6:1]};
        end
        return w;
    endfunction

    // Predictor state after producing one full word.
    function automatic logic [6:0] prbs_next(input logic [6:0] s);
        logic [6:0] t;
        logic       b;
        t = s;
        for (int i = 0; i < W; i++) begin
            b = t[1] ^ t[0];
            t = {b, t[6:1]};
        end
        return t;
    endfunction

    function automatic logic [PCW-1:0] popcount(input logic [W-1:0] v);
        logic [PCW-1:0] c;
        c = '0;
        for (int i = 0; i < W; i++) begin
            c = c + PCW'(v[i]);
        end
        return c;
    endfunction

    // The last seven bits of a received word are exactly the generator
    // state that follows it, newest bit in s[6]. A zero predictor state is
    // the LFSR lock-up state, so it is never accepted as a match; this keeps
    // an all-zero stream (dead link) from ever declaring lock.
    always_comb begin
        exp_word   = prbs_word(pred_state);
        exp_next   = prbs_next(pred_state);
        bit_errs   = popcount(link.rx_data ^ exp_word);
        rx_state   = link.rx_data[W-1 -: 7];
        word_match = (link.rx_data == exp_word) && (pred_state != 7'h00);
        word_inc   = word_count + CNTW'(1);
        err_wide   = {1'b0, err_count} + (CNTW + 1)'(bit_errs);
        err_sum    = err_wide[CNTW] ? '1 : err_wide[CNTW-1:0];
    end

    assign link.gen_reset = gen_reset_q;
    assign link.gen_dis   = gen_dis_q;
    assign link.gen_seed  = gen_seed_q;

    // Main sequencer. Every output is registered and set on the transition
    // into the state it belongs to, so it is valid for the whole state.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= S_IDLE;
            gen_reset_q <= 1'b1;
            gen_dis_q   <= 1'b1;
            gen_seed_q  <= 7'h7F;
            busy        <= 1'b0;
            locked      <= 1'b0;
            done        <= 1'b0;
            lock_lost   <= 1'b0;
            word_count  <= '0;
            err_count   <= '0;
            pred_state  <= 7'h7F;
            match_cnt   <= '0;
            bad_run     <= '0;
            sync_first  <= 1'b0;
        end else if (abort) begin
            state       <= S_IDLE;
            gen_reset_q <= 1'b1;
            gen_dis_q   <= 1'b1;
            busy        <= 1'b0;
            locked      <= 1'b0;
            done        <= 1'b0;
        end else begin
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state       <= S_SEED;
                        gen_seed_q  <= (seed == 7'h00) ? 7'h7F : seed;
                        gen_reset_q <= 1'b0;
                        gen_dis_q   <= 1'b0;
                        busy        <= 1'b1;
                        done        <= 1'b0;
                        locked      <= 1'b0;
                        lock_lost   <= 1'b0;
                        word_count  <= '0;
                        err_count   <= '0;
                    end
                end

                S_SEED: begin
                    state       <= S_SYNC;
                    gen_reset_q <= 1'b1;
                    gen_dis_q   <= 1'b0;
                    sync_first  <= 1'b1;
                    match_cnt   <= '0;
                end

                // Free-running search: a mismatch (or the first word) reloads
                // the predictor from the received word and restarts the run.
                S_SYNC: begin
                    if (link.rx_valid) begin
                        if (!sync_first && word_match) begin
                            pred_state <= exp_next;
                            if (match_cnt == SYNC_LAST) begin
                                state   <= S_CHECK;
                                locked  <= 1'b1;
                                bad_run <= '0;
                            end else begin
                                match_cnt <= match_cnt + MCW'(1);
                            end
                        end else begin
                            pred_state <= rx_state;
                            match_cnt  <= '0;
                            sync_first <= 1'b0;
                        end
                    end
                end

                // The predictor advances from its own state only, so a
                // corrupted word is counted once and never propagates.
                // Reaching the word target wins over a simultaneous loss.
                S_CHECK: begin
                    if (link.rx_valid) begin
                        word_count <= word_inc;
                        err_count  <= err_sum;
                        pred_state <= exp_next;
                        if (bit_errs != '0) begin
                            bad_run <= (bad_run == LOSS_LAST) ? '0 : bad_run + BCW'(1);
                        end else begin
                            bad_run <= '0;
                        end

                        if ((num_words != '0) && (word_inc == num_words)) begin
                            state     <= S_DONE;
                            done      <= 1'b1;
                            busy      <= 1'b0;
                            locked    <= 1'b0;
                            gen_dis_q <= 1'b1;
                        end else if ((bit_errs != '0) && (bad_run == LOSS_LAST)) begin
                            state      <= S_SYNC;
                            locked     <= 1'b0;
                            lock_lost  <= 1'b1;
                            sync_first <= 1'b1;
                            match_cnt  <= '0;
                        end
                    end
                end

                default: begin
                    state       <= S_IDLE;
                    gen_reset_q <= 1'b1;
                    gen_dis_q   <= 1'b1;
                    busy        <= 1'b0;
                    locked      <= 1'b0;
                    done        <= 1'b0;
                end
            endcase
        end
    end

endmodule
